// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART frame definitions: FSM state encodings and data-frame constants,
// common to the transmitter and the matching receiver.
package uart_tx_buffered_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    START_BIT = 3'b001,
    DATA_BITS = 3'b010,
    STOP_BIT  = 3'b011,
    CLEANUP   = 3'b100
  } tx_state_e;

  localparam int NUM_DATA_BITS = 8;
  localparam int IDX_W         = $clog2(NUM_DATA_BITS);

  typedef logic [NUM_DATA_BITS-1:0] byte_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; rdata shows the head entry combinationally.
// Flags decode from the registered count; a push while full is dropped even if a pop coincides.
module uart_tx_fifo
  import uart_tx_buffered_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  push,
  input  logic  pop,
  input  byte_t wdata,
  output byte_t rdata,
  output logic  full,
  output logic  empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  byte_t            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because the depth is a power of two.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter (8N1): first start bit appears two cycles after a byte is accepted,
// frames repeat every 10*CLOCKS_PER_BIT+2 cycles; ready drops only when the input FIFO is full.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 87,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] data_to_send,
  output logic       ready,
  output logic       outgoing_bit,
  output logic       is_transmitting,
  output logic       done
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DATA_BITS - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  byte_t            shift_q, shift_d;
  logic             line_q, line_d;
  logic             fifo_pop, fifo_full, fifo_empty;
  byte_t            fifo_rdata;

  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (send),
    .pop   (fifo_pop),
    .wdata (data_to_send),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    line_d   = 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          state_d  = START_BIT;
        end
      end
      START_BIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA_BITS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA_BITS: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) state_d = STOP_BIT;
          else                   idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP_BIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = CLEANUP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLEANUP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The line is registered, so its next value follows the next state.
    case (state_d)
      START_BIT: line_d = 1'b0;
      DATA_BITS: line_d = shift_d[idx_d];
      default:   line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      line_q  <= line_d;
    end
  end

  assign ready           = !fifo_full;
  assign outgoing_bit    = line_q;
  assign is_transmitting = (state_q == START_BIT) || (state_q == DATA_BITS) || (state_q == STOP_BIT);
  assign done            = (state_q == CLEANUP);

endmodule
